// File: rtl/counter_mod_updown.sv
// counter_mod_updown: modulo-MAX up/down counter with clear, load, wrap/saturate and a registered terminal-count pulse
// Ports: clk (rising edge), rst (sync, active-low), enable (step request), up_down (1 up / 0 down),
//        clear (sync clear), load/load_val (parallel load, clamped to MAX), Q (count), tc (registered
//        terminal-count pulse), at_term (combinational: Q at MAX going up or 0 going down).
// Define COUNTER_OVF_STICKY_EN to add ovf_clr (input) and ovf (sticky registered overflow flag).
module counter_mod_updown #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             at_term
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    if (WIDTH < 2 || MAX < 1 || longint'(MAX) > (longint'(1) << WIDTH) - 1) begin : g_bad_param
        $error("counter_mod_updown: need WIDTH>=2 and 1 <= MAX <= 2^WIDTH-1");
    end
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             term_step;
    // Going up, anything at or above MAX is terminal so a forced out-of-range count recovers on the next step.
    assign term_step = enable & (up_down ? q_q >= MAX_V : q_q == '0);
    always_comb begin
        tc_d = ~clear & ~load & term_step;
        q_d  = clear    ? '0 :
               load     ? (load_val > MAX_V ? MAX_V : load_val) :
               !enable  ? q_q :
               up_down  ? (term_step ? (SATURATE ? MAX_V : '0) : q_q + WIDTH'(1)) :
                          (term_step ? (SATURATE ? '0 : MAX_V) : q_q - WIDTH'(1));
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end
`ifdef COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;
    // A terminal step sets the flag even when ovf_clr is asserted in the same cycle.
    assign ovf_d = tc_d | (ovf_q & ~clear & ~ovf_clr);
    always_ff @(posedge clk) begin
        if (!rst) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif
    assign Q       = q_q;
    assign tc      = tc_q;
    assign at_term = up_down ? q_q == MAX_V : q_q == '0;
endmodule

// File: tb/tb_counter_mod_updown.sv
// tb_counter_mod_updown: checks a wrapping (WIDTH=4, MAX=9) and a saturating (WIDTH=8, MAX=200) counter against a reference model
module tb_counter_mod_updown;
    logic       clk = 1'b0;
    logic       rst, enable, up_down, clear, load, ovf_clr;
    logic [7:0] load_val;
    logic [3:0] q0;
    logic [7:0] q1;
    logic       tc0, tc1, at0, at1;
    logic       ovf0, ovf1;
    int         checks = 0, errors = 0;
    bit         chk_on = 1'b0;
    int         mq[2], mtc[2], movf[2];
    int         mx[2]  = '{9, 200};
    bit         sat[2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    counter_mod_updown #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
        .load_val(load_val[3:0]),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(ovf0),
`endif
        .Q(q0), .tc(tc0), .at_term(at0));

    counter_mod_updown #(.WIDTH(8), .MAX(200), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
        .load_val(load_val),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(ovf1),
`endif
        .Q(q1), .tc(tc1), .at_term(at1));

`ifndef COUNTER_OVF_STICKY_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    function automatic bit term(int i);
        return rst && !clear && !load && enable && (up_down ? mq[i] >= mx[i] : mq[i] == 0);
    endfunction

    function automatic int nxt_q(int i);
        int lv = (i == 0) ? int'(load_val) % 16 : int'(load_val);
        if (!rst || clear) return 0;
        if (load) return lv > mx[i] ? mx[i] : lv;
        if (!enable) return mq[i];
        if (term(i)) return (up_down ^ sat[i]) ? 0 : mx[i];
        return up_down ? mq[i] + 1 : mq[i] - 1;
    endfunction

    function automatic int nxt_ovf(int i);
        if (!rst || clear) return 0;
        if (term(i)) return 1;
        return ovf_clr ? 0 : movf[i];
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 2; i++) begin
            mq[i]   <= nxt_q(i);
            mtc[i]  <= int'(term(i));
            movf[i] <= nxt_ovf(i);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk)
        if (chk_on) begin
            chk("q0", 32'(q0), mq[0]);
            chk("tc0", 32'(tc0), mtc[0]);
            chk("at0", 32'(at0), up_down ? int'(mq[0] == mx[0]) : int'(mq[0] == 0));
            chk("q1", 32'(q1), mq[1]);
            chk("tc1", 32'(tc1), mtc[1]);
            chk("at1", 32'(at1), up_down ? int'(mq[1] == mx[1]) : int'(mq[1] == 0));
`ifdef COUNTER_OVF_STICKY_EN
            chk("ovf0", 32'(ovf0), movf[0]);
            chk("ovf1", 32'(ovf1), movf[1]);
`endif
        end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set(input bit r, input bit en, input bit ud, input bit cl, input bit ld, input int lv);
        rst = r; enable = en; up_down = ud; clear = cl; load = ld; load_val = 8'(lv); ovf_clr = 1'b0;
    endtask

    initial begin
        set(0, 1, 1, 0, 1, 8'h55);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("rst_q0", 32'(q0), 0);
            chk("rst_q1", 32'(q1), 0);
            chk("rst_tc0", 32'(tc0), 0);
            chk_on = 1'b1;
        end
        set(1, 0, 1, 0, 0, 0);
        cyc();
        chk("idle_q0", 32'(q0), 0);
        set(1, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("upwrap_q", 32'(q0), k % 10);
            chk("upwrap_tc", 32'(tc0), int'(k == 10));
            chk("upwrap_at", 32'(at0), int'(k == 9));
        end
        set(1, 0, 1, 1, 0, 0);
        cyc();
        set(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("dnwrap_q", 32'(q0), 9 - k);
            chk("dnwrap_tc", 32'(tc0), int'(k == 0));
        end
        set(1, 0, 1, 0, 1, 199);
        cyc();
        chk("sat_load", 32'(q1), 199);
        set(1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("sat_q", 32'(q1), 200);
            chk("sat_tc", 32'(tc1), int'(k > 0));
        end
        set(1, 0, 1, 0, 1, 5);
        cyc();
        set(1, 1, 1, 1, 1, 7);
        cyc();
        chk("clr_wins", 32'(q0), 0);
        chk("clr_wins1", 32'(q1), 0);
        set(1, 0, 1, 0, 1, 250);
        cyc();
        chk("clamp1", 32'(q1), 200);
        chk("clamp0", 32'(q0), 9);
        set(1, 1, 1, 0, 1, 100);
        cyc();
        chk("ld_wins1", 32'(q1), 100);
        chk("ld_wins0", 32'(q0), 4);
`ifdef COUNTER_OVF_STICKY_EN
        set(1, 0, 1, 1, 0, 0);
        cyc();
        set(1, 0, 1, 0, 1, 9);
        cyc();
        set(1, 1, 1, 0, 0, 0);
        cyc();
        chk("ovf_set", 32'(ovf0), 1);
        set(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc();
        chk("ovf_hold", 32'(ovf0), 1);
        set(1, 0, 1, 0, 1, 9);
        cyc();
        set(1, 1, 1, 0, 0, 0);
        ovf_clr = 1'b1;
        cyc();
        chk("ovf_setwins", 32'(ovf0), 1);
        set(1, 0, 1, 0, 0, 0);
        ovf_clr = 1'b1;
        cyc();
        chk("ovf_clr", 32'(ovf0), 0);
`endif
        for (int k = 0; k < 3000; k++) begin
            set($urandom_range(49) != 0, $urandom_range(3) != 0, $urandom_range(2) != 0,
                $urandom_range(19) == 0, $urandom_range(9) == 0, int'($urandom_range(255)));
            ovf_clr = $urandom_range(7) == 0;
            cyc();
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
